// File: rtl/pe_memory_arbiter_if.sv
// Requester, clear-control and scratchpad-port signals shared by the PE memory arbiter.
// The arbiter connects through the slave modport; requesters and the memory sit on master.
interface pe_memory_arbiter_if #(
   parameter int ADDR_WIDTH = 6,
   parameter int NUM_BITS   = 8
);
   logic                  w_a_req;
   logic                  w_a_rw;
   logic [ADDR_WIDTH-1:0] w_a_addr;
   logic [NUM_BITS-1:0]   w_a_wdata;
   logic                  r_a_gnt;
   logic                  r_a_rvalid;
   logic [NUM_BITS-1:0]   r_a_rdata;

   logic                  w_b_req;
   logic                  w_b_rw;
   logic [ADDR_WIDTH-1:0] w_b_addr;
   logic [NUM_BITS-1:0]   w_b_wdata;
   logic                  r_b_gnt;
   logic                  r_b_rvalid;
   logic [NUM_BITS-1:0]   r_b_rdata;

   logic                  w_clear;
   logic                  r_clear_busy;

   logic                  r_mem_ready;
   logic                  r_mem_rw;
   logic [ADDR_WIDTH-1:0] r_mem_address;
   logic [NUM_BITS-1:0]   r_mem_data_in;
   logic [NUM_BITS-1:0]   w_mem_data_out;

   modport slave (
      input  w_a_req, w_a_rw, w_a_addr, w_a_wdata,
      output r_a_gnt, r_a_rvalid, r_a_rdata,
      input  w_b_req, w_b_rw, w_b_addr, w_b_wdata,
      output r_b_gnt, r_b_rvalid, r_b_rdata,
      input  w_clear,
      output r_clear_busy,
      output r_mem_ready, r_mem_rw, r_mem_address, r_mem_data_in,
      input  w_mem_data_out
   );

   modport master (
      output w_a_req, w_a_rw, w_a_addr, w_a_wdata,
      input  r_a_gnt, r_a_rvalid, r_a_rdata,
      output w_b_req, w_b_rw, w_b_addr, w_b_wdata,
      input  r_b_gnt, r_b_rvalid, r_b_rdata,
      output w_clear,
      input  r_clear_busy,
      input  r_mem_ready, r_mem_rw, r_mem_address, r_mem_data_in,
      output w_mem_data_out
   );
endinterface

// File: rtl/pe_memory_arbiter.sv
// Round-robin arbiter sharing one single-port PE scratchpad between requesters A and B,
// with read/write turnaround and a sequenced whole-array clear.
//
// state         | meaning
// ST_RUN        | normal arbitration; idle cycles issue a harmless read of row 0
// ST_CLEAR_WAIT | clear requested while a read was in flight; deliver it, no grants
// ST_CLEAR      | memory enable held low for CLEAR_CYCLES cycles, no grants
module pe_memory_arbiter #(
   parameter int NUM_ROWS     = 64,
   parameter int ADDR_WIDTH   = $clog2(NUM_ROWS),
   parameter int NUM_BITS     = 8,
   parameter int CLEAR_CYCLES = 2
) (
   input logic         w_clk,
   input logic         w_rst_n,
   pe_memory_arbiter_if.slave bus
);
   localparam int CNT_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;

   if (CLEAR_CYCLES < 1 || (2 ** ADDR_WIDTH) < NUM_ROWS) begin : g_bad_param
      $error("pe_memory_arbiter: CLEAR_CYCLES must be >= 1 and ADDR_WIDTH must cover NUM_ROWS");
   end

   typedef enum logic [1:0] {
      ST_RUN        = 2'd0,
      ST_CLEAR_WAIT = 2'd1,
      ST_CLEAR      = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic             ptr_q, ptr_d;          // 0 favours A, 1 favours B
   logic [CNT_W-1:0] clr_cnt_q, clr_cnt_d;
   logic             rd_a_q, rd_a_d;
   logic             rd_b_q, rd_b_d;
   logic             turn, elig_a, elig_b, gnt_a, gnt_b;

   always_ff @(posedge w_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         state_q   <= ST_RUN;
         ptr_q     <= 1'b0;
         clr_cnt_q <= '0;
         rd_a_q    <= 1'b0;
         rd_b_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         clr_cnt_q <= clr_cnt_d;
         rd_a_q    <= rd_a_d;
         rd_b_q    <= rd_b_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      clr_cnt_d = clr_cnt_q;
      rd_a_d    = gnt_a && !bus.w_a_rw;
      rd_b_d    = gnt_b && !bus.w_b_rw;
      // contention moves priority to the loser, even when the winner won only because the other was stalled
      if (bus.w_a_req && bus.w_b_req && (gnt_a || gnt_b)) begin
         ptr_d = gnt_a;
      end
      case (state_q)
         ST_RUN: begin
            if (bus.w_clear) begin
               if (rd_a_d || rd_b_d) begin
                  state_d = ST_CLEAR_WAIT;
               end else begin
                  state_d   = ST_CLEAR;
                  clr_cnt_d = CNT_W'(CLEAR_CYCLES - 1);
               end
            end
         end
         ST_CLEAR_WAIT: begin
            state_d   = ST_CLEAR;
            clr_cnt_d = CNT_W'(CLEAR_CYCLES - 1);
         end
         ST_CLEAR: begin
            if (clr_cnt_q == '0) begin
               state_d = ST_RUN;
            end else begin
               clr_cnt_d = clr_cnt_q - CNT_W'(1);
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_comb begin
      // the cycle after a read grant must stay at the read level so its data remains visible
      turn   = rd_a_q || rd_b_q;
      elig_a = w_rst_n && (state_q == ST_RUN) && bus.w_a_req && !(bus.w_a_rw && turn);
      elig_b = w_rst_n && (state_q == ST_RUN) && bus.w_b_req && !(bus.w_b_rw && turn);
      if (elig_a && elig_b) begin
         gnt_a = !ptr_q;
         gnt_b = ptr_q;
      end else begin
         gnt_a = elig_a;
         gnt_b = elig_b;
      end

      bus.r_mem_ready   = w_rst_n && (state_q != ST_CLEAR);
      bus.r_mem_rw      = 1'b0;
      bus.r_mem_address = '0;
      bus.r_mem_data_in = '0;
      if (gnt_a) begin
         bus.r_mem_rw      = bus.w_a_rw;
         bus.r_mem_address = bus.w_a_addr;
         bus.r_mem_data_in = bus.w_a_wdata;
      end else if (gnt_b) begin
         bus.r_mem_rw      = bus.w_b_rw;
         bus.r_mem_address = bus.w_b_addr;
         bus.r_mem_data_in = bus.w_b_wdata;
      end

      bus.r_a_gnt      = gnt_a;
      bus.r_b_gnt      = gnt_b;
      bus.r_a_rvalid   = rd_a_q;
      bus.r_b_rvalid   = rd_b_q;
      bus.r_a_rdata    = rd_a_q ? bus.w_mem_data_out : '0;
      bus.r_b_rdata    = rd_b_q ? bus.w_mem_data_out : '0;
      bus.r_clear_busy = (state_q != ST_RUN);
   end
endmodule

// File: tb/tb_pe_memory_arbiter.sv
// Bench for pe_memory_arbiter: scratchpad model, transaction-level reference checked every
// cycle, directed scenarios for the key corner cases, then random traffic with clears.
module tb_pe_memory_arbiter;
   localparam int NUM_ROWS = 64;
   localparam int AW       = 6;
   localparam int NB       = 8;
   localparam int CC       = 2;

   logic w_clk = 1'b0;
   logic w_rst_n = 1'b0;

   pe_memory_arbiter_if #(.ADDR_WIDTH(AW), .NUM_BITS(NB)) bus ();

   pe_memory_arbiter #(
      .NUM_ROWS(NUM_ROWS), .ADDR_WIDTH(AW), .NUM_BITS(NB), .CLEAR_CYCLES(CC)
   ) dut (
      .w_clk(w_clk),
      .w_rst_n(w_rst_n),
      .bus(bus)
   );

   always #5 w_clk = ~w_clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // single-port scratchpad: write level stores, read level registers the row, enable low clears
   logic [NB-1:0] mem [NUM_ROWS];
   logic [NB-1:0] dout_q;
   always @(posedge w_clk) begin
      if (!bus.r_mem_ready) begin
         for (int i = 0; i < NUM_ROWS; i++) mem[i] <= '0;
      end else if (bus.r_mem_rw) begin
         mem[bus.r_mem_address] <= bus.r_mem_data_in;
      end else begin
         dout_q <= mem[bus.r_mem_address];
      end
   end
   assign bus.w_mem_data_out = (bus.r_mem_ready && !bus.r_mem_rw) ? dout_q : '0;

   // reference: expected contents, who wins contention next, pending read returns, clear phase
   logic [NB-1:0] shadow [NUM_ROWS];
   int            m_phase;   // 0 running, 1 waiting for read return, 2 clearing
   int            m_left;
   bit            m_prio_b, m_last_rd, m_pend_a, m_pend_b;
   logic [NB-1:0] m_data_a, m_data_b;
   bit            a_taken, b_taken;

   always @(negedge w_clk) begin
      bit ga, gb, ea, eb, rd_now, wr_now;
      if (!w_rst_n) begin
         for (int i = 0; i < NUM_ROWS; i++) shadow[i] = '0;
         m_phase = 0; m_left = 0; m_prio_b = 0; m_last_rd = 0;
         m_pend_a = 0; m_pend_b = 0; m_data_a = '0; m_data_b = '0;
         a_taken = 0; b_taken = 0;
      end else begin
         ga = 0; gb = 0;
         if (m_phase == 0) begin
            ea = bus.w_a_req && !(bus.w_a_rw && m_last_rd);
            eb = bus.w_b_req && !(bus.w_b_rw && m_last_rd);
            if (ea && eb) begin
               ga = !m_prio_b; gb = m_prio_b;
            end else begin
               ga = ea; gb = eb;
            end
         end
         chk("gnt_a", bus.r_a_gnt, ga);
         chk("gnt_b", bus.r_b_gnt, gb);
         chk("rvalid_a", bus.r_a_rvalid, m_pend_a);
         chk("rvalid_b", bus.r_b_rvalid, m_pend_b);
         chk("rdata_a", bus.r_a_rdata, m_pend_a ? m_data_a : 8'h00);
         chk("rdata_b", bus.r_b_rdata, m_pend_b ? m_data_b : 8'h00);
         chk("clear_busy", bus.r_clear_busy, m_phase != 0);
         chk("mem_ready", bus.r_mem_ready, m_phase != 2);
         wr_now = (ga && bus.w_a_rw) || (gb && bus.w_b_rw);
         rd_now = (ga && !bus.w_a_rw) || (gb && !bus.w_b_rw);
         chk("mem_rw", bus.r_mem_rw, wr_now);
         if (ga || gb) chk("mem_addr", bus.r_mem_address, ga ? bus.w_a_addr : bus.w_b_addr);
         if (wr_now) chk("mem_wdata", bus.r_mem_data_in, ga ? bus.w_a_wdata : bus.w_b_wdata);

         a_taken = bus.r_a_gnt;
         b_taken = bus.r_b_gnt;
         m_pend_a = ga && !bus.w_a_rw;
         m_pend_b = gb && !bus.w_b_rw;
         if (m_pend_a) m_data_a = shadow[bus.w_a_addr];
         if (m_pend_b) m_data_b = shadow[bus.w_b_addr];
         if (wr_now) begin
            if (ga) shadow[bus.w_a_addr] = bus.w_a_wdata;
            else    shadow[bus.w_b_addr] = bus.w_b_wdata;
         end
         if (bus.w_a_req && bus.w_b_req && (ga || gb)) m_prio_b = ga;
         m_last_rd = rd_now;
         case (m_phase)
            0: if (bus.w_clear) begin
                  if (rd_now) m_phase = 1;
                  else begin
                     m_phase = 2; m_left = CC;
                     for (int i = 0; i < NUM_ROWS; i++) shadow[i] = '0;
                  end
               end
            1: begin
                  m_phase = 2; m_left = CC;
                  for (int i = 0; i < NUM_ROWS; i++) shadow[i] = '0;
               end
            default: begin
                  m_left--;
                  if (m_left == 0) m_phase = 0;
               end
         endcase
      end
   end

   task automatic tick();
      @(posedge w_clk);
      #1;
   endtask

   task automatic idle_all();
      bus.w_a_req = 0; bus.w_b_req = 0; bus.w_clear = 0;
   endtask

   // issue one access and hold it until granted; returns at posedge+1 with the request dropped
   task automatic access(input bit side, input bit rw, input logic [AW-1:0] ad,
                         input logic [NB-1:0] d);
      int n = 0;
      if (side) begin
         bus.w_b_req = 1; bus.w_b_rw = rw; bus.w_b_addr = ad; bus.w_b_wdata = d;
      end else begin
         bus.w_a_req = 1; bus.w_a_rw = rw; bus.w_a_addr = ad; bus.w_a_wdata = d;
      end
      @(negedge w_clk);
      while (!(side ? bus.r_b_gnt : bus.r_a_gnt) && n < 20) begin
         tick();
         @(negedge w_clk);
         n++;
      end
      if (n >= 20) chk("access_timeout", n, 0);
      tick();
      if (side) bus.w_b_req = 0; else bus.w_a_req = 0;
   endtask

   task automatic read_chk(input bit side, input logic [AW-1:0] ad, input logic [NB-1:0] exp,
                           input string tag);
      access(side, 0, ad, '0);
      @(negedge w_clk);
      chk(tag, side ? bus.r_b_rdata : bus.r_a_rdata, exp);
      tick();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n, n_low;
      idle_all();
      bus.w_a_rw = 0; bus.w_a_addr = '0; bus.w_a_wdata = '0;
      bus.w_b_rw = 0; bus.w_b_addr = '0; bus.w_b_wdata = '0;
      bus.w_a_req = 1;
      repeat (3) @(posedge w_clk);
      #1;
      chk("rst_ready", bus.r_mem_ready, 0);
      chk("rst_busy", bus.r_clear_busy, 0);
      chk("rst_gnt_a", bus.r_a_gnt, 0);
      chk("rst_rw", bus.r_mem_rw, 0);
      chk("rst_addr", bus.r_mem_address, 0);
      bus.w_a_req = 0;
      w_rst_n = 1;

      // write then read back row 3
      bus.w_a_req = 1; bus.w_a_rw = 1; bus.w_a_addr = 6'd3; bus.w_a_wdata = 8'hA5;
      @(negedge w_clk); chk("t1_wgnt", bus.r_a_gnt, 1);
      tick(); bus.w_a_rw = 0;
      @(negedge w_clk); chk("t1_rgnt", bus.r_a_gnt, 1);
      tick(); bus.w_a_req = 0;
      @(negedge w_clk);
      chk("t1_rvalid", bus.r_a_rvalid, 1);
      chk("t1_rdata", bus.r_a_rdata, 8'hA5);
      tick();

      // alternating reads under contention
      access(0, 1, 6'd1, 8'h11);
      access(0, 1, 6'd2, 8'h22);
      bus.w_a_req = 1; bus.w_a_rw = 0; bus.w_a_addr = 6'd1;
      bus.w_b_req = 1; bus.w_b_rw = 0; bus.w_b_addr = 6'd2;
      for (int i = 0; i < 6; i++) begin
         @(negedge w_clk);
         chk("t2_alt_a", bus.r_a_gnt, (i % 2) == 0);
         chk("t2_alt_b", bus.r_b_gnt, (i % 2) == 1);
         if (i % 2 == 1) chk("t2_rdata_a", bus.r_a_rdata, 8'h11);
         if (i > 0 && i % 2 == 0) chk("t2_rdata_b", bus.r_b_rdata, 8'h22);
         tick();
      end
      idle_all();
      tick();

      // read then write: turnaround stall
      access(1, 1, 6'd5, 8'h5A);
      bus.w_a_req = 1; bus.w_a_rw = 0; bus.w_a_addr = 6'd5;
      @(negedge w_clk); chk("t3_a_gnt", bus.r_a_gnt, 1);
      tick();
      bus.w_a_req = 0;
      bus.w_b_req = 1; bus.w_b_rw = 1; bus.w_b_addr = 6'd9; bus.w_b_wdata = 8'h3C;
      @(negedge w_clk);
      chk("t3_b_block", bus.r_b_gnt, 0);
      chk("t3_rw_low", bus.r_mem_rw, 0);
      chk("t3_a_rdata", bus.r_a_rdata, 8'h5A);
      tick();
      @(negedge w_clk);
      chk("t3_b_gnt", bus.r_b_gnt, 1);
      chk("t3_rw_high", bus.r_mem_rw, 1);
      tick();
      bus.w_b_req = 0;
      read_chk(0, 6'd9, 8'h3C, "t3_readback");

      // clear: exactly CC cycles of enable low, no grants while busy, rows read zero
      access(0, 1, 6'd0, 8'hFF);
      access(0, 1, 6'd63, 8'hFF);
      read_chk(1, 6'd63, 8'hFF, "t4_pre63");
      bus.w_clear = 1;
      @(negedge w_clk); chk("t4_busy_pre", bus.r_clear_busy, 0);
      tick();
      bus.w_clear = 0;
      bus.w_b_req = 1; bus.w_b_rw = 0; bus.w_b_addr = 6'd63;
      n = 0; n_low = 0;
      while (n < 10) begin
         @(negedge w_clk);
         if (!bus.r_clear_busy) break;
         if (!bus.r_mem_ready) n_low++;
         chk("t4_no_gnt", bus.r_b_gnt, 0);
         tick();
         n++;
      end
      chk("t4_low_cycles", n_low, CC);
      chk("t4_gnt_after", bus.r_b_gnt, 1);
      tick();
      bus.w_b_req = 0;
      @(negedge w_clk); chk("t4_rd63", bus.r_b_rdata, 8'h00);
      tick();
      read_chk(0, 6'd0, 8'h00, "t4_rd0");

      // clear sampled together with a read grant
      access(0, 1, 6'd1, 8'h77);
      bus.w_a_req = 1; bus.w_a_rw = 0; bus.w_a_addr = 6'd1; bus.w_clear = 1;
      @(negedge w_clk); chk("t5_gnt", bus.r_a_gnt, 1);
      tick();
      bus.w_a_req = 0; bus.w_clear = 0;
      @(negedge w_clk);
      chk("t5_wait_busy", bus.r_clear_busy, 1);
      chk("t5_wait_ready", bus.r_mem_ready, 1);
      chk("t5_rvalid", bus.r_a_rvalid, 1);
      chk("t5_rdata", bus.r_a_rdata, 8'h77);
      tick();
      for (int i = 0; i < CC; i++) begin
         @(negedge w_clk); chk("t5_clear_low", bus.r_mem_ready, 0);
         tick();
      end
      @(negedge w_clk); chk("t5_done", bus.r_clear_busy, 0);
      tick();

      // move priority to B, then reset mid-clear and mid-read
      bus.w_a_req = 1; bus.w_a_rw = 0; bus.w_a_addr = 6'd2;
      bus.w_b_req = 1; bus.w_b_rw = 0; bus.w_b_addr = 6'd2;
      @(negedge w_clk); chk("t6_pre_a", bus.r_a_gnt, 1);
      tick();
      idle_all();
      bus.w_clear = 1;
      tick();
      bus.w_clear = 0;
      tick();
      bus.w_a_req = 1; bus.w_a_rw = 0; bus.w_a_addr = 6'd1;
      #2;
      chk("t6_in_clear", bus.r_mem_ready, 0);
      w_rst_n = 0;
      #1;
      chk("t6_rst_ready", bus.r_mem_ready, 0);
      chk("t6_rst_busy", bus.r_clear_busy, 0);
      chk("t6_rst_gnt", bus.r_a_gnt, 0);
      chk("t6_rst_addr", bus.r_mem_address, 0);
      tick();
      w_rst_n = 1;
      @(negedge w_clk); chk("t6_rd_gnt", bus.r_a_gnt, 1);
      tick();
      bus.w_a_req = 0;
      chk("t6_rvalid_pre", bus.r_a_rvalid, 1);
      w_rst_n = 0;
      #1;
      chk("t6_rvalid_drop", bus.r_a_rvalid, 0);
      chk("t6_rdata_drop", bus.r_a_rdata, 0);
      tick();
      w_rst_n = 1;
      bus.w_a_req = 1; bus.w_b_req = 1; bus.w_a_rw = 0; bus.w_b_rw = 0;
      @(negedge w_clk); chk("t6_ptr_a", bus.r_a_gnt, 1);
      tick();
      idle_all();
      tick();

      // random traffic
      for (int c = 0; c < 3000; c++) begin
         if (!bus.w_a_req || a_taken) begin
            bus.w_a_req   = $urandom_range(0, 99) < 60;
            bus.w_a_rw    = 1'($urandom_range(0, 1));
            bus.w_a_addr  = ($urandom_range(0, 3) == 0) ? 6'd63 : AW'($urandom_range(0, 7));
            bus.w_a_wdata = NB'($urandom);
         end
         if (!bus.w_b_req || b_taken) begin
            bus.w_b_req   = $urandom_range(0, 99) < 60;
            bus.w_b_rw    = 1'($urandom_range(0, 1));
            bus.w_b_addr  = ($urandom_range(0, 3) == 0) ? 6'd63 : AW'($urandom_range(0, 7));
            bus.w_b_wdata = NB'($urandom);
         end
         bus.w_clear = ($urandom_range(0, 79) == 0);
         tick();
      end
      idle_all();
      repeat (4) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
